// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter in front of the CPU-side IO request port.
// A registered request stage feeds the port; an in-order owner FIFO steers read returns.
module io_bus_arbiter #(
  parameter int P_TAG_DEPTH = 4,
  parameter int P_TAG_AW    = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iM0_REQ,
  output logic        oM0_BUSY,
  input  logic [1:0]  iM0_ORDER,
  input  logic        iM0_RW,
  input  logic [31:0] iM0_ADDR,
  input  logic [31:0] iM0_DATA,
  output logic        oM0_VALID,
  input  logic        iM0_BUSY,
  output logic [31:0] oM0_DATA,
  input  logic        iM1_REQ,
  output logic        oM1_BUSY,
  input  logic [1:0]  iM1_ORDER,
  input  logic        iM1_RW,
  input  logic [31:0] iM1_ADDR,
  input  logic [31:0] iM1_DATA,
  output logic        oM1_VALID,
  input  logic        iM1_BUSY,
  output logic [31:0] oM1_DATA,
  output logic        oIO_REQ,
  input  logic        iIO_BUSY,
  output logic [1:0]  oIO_ORDER,
  output logic        oIO_RW,
  output logic [31:0] oIO_ADDR,
  output logic [31:0] oIO_DATA,
  input  logic        iIO_VALID,
  output logic        oIO_BUSY,
  input  logic [31:0] iIO_DATA,
  output logic        oERR_UNEXP
);

  logic                   out_valid_q, out_valid_d;
  logic [1:0]             order_q, order_d;
  logic                   rw_q, rw_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   pref_q, pref_d;
  logic [P_TAG_DEPTH-1:0] own_q, own_d;
  logic [P_TAG_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [P_TAG_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [P_TAG_AW:0]      cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic fifo_ne_s, head_s, io_busy_s, pop_s, full_s, can_load_s;
  logic elig0_s, elig1_s, gnt0_s, gnt1_s, push_s;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a read.
  assign fifo_ne_s  = (cnt_q != '0);
  assign head_s     = own_q[rd_ptr_q];
  assign io_busy_s  = fifo_ne_s && (head_s ? iM1_BUSY : iM0_BUSY);
  assign pop_s      = iIO_VALID && fifo_ne_s && !io_busy_s;
  assign full_s     = (cnt_q == (P_TAG_AW+1)'(P_TAG_DEPTH)) && !pop_s;
  assign can_load_s = !out_valid_q || !iIO_BUSY;

  assign elig0_s = iM0_REQ && can_load_s && !(iM0_RW && full_s);
  assign elig1_s = iM1_REQ && can_load_s && !(iM1_RW && full_s);
  // pref_q == 0 means master 0 is preferred.
  assign gnt0_s  = elig0_s && (!elig1_s || !pref_q);
  assign gnt1_s  = elig1_s && (!elig0_s || pref_q);
  assign push_s  = (gnt0_s && iM0_RW) || (gnt1_s && iM1_RW);

  assign oM0_BUSY   = !can_load_s || (iM0_RW && full_s) || gnt1_s;
  assign oM1_BUSY   = !can_load_s || (iM1_RW && full_s) || gnt0_s;
  assign oM0_VALID  = iIO_VALID && fifo_ne_s && !head_s;
  assign oM1_VALID  = iIO_VALID && fifo_ne_s && head_s;
  assign oM0_DATA   = oM0_VALID ? iIO_DATA : 32'h0000_0000;
  assign oM1_DATA   = oM1_VALID ? iIO_DATA : 32'h0000_0000;
  assign oIO_BUSY   = io_busy_s;
  assign oIO_REQ    = out_valid_q;
  assign oIO_ORDER  = order_q;
  assign oIO_RW     = rw_q;
  assign oIO_ADDR   = addr_q;
  assign oIO_DATA   = data_q;
  assign oERR_UNEXP = err_q;

  always_comb begin
    out_valid_d = out_valid_q;
    order_d     = order_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pref_d      = pref_q;
    own_d       = own_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    if (gnt0_s) begin
      out_valid_d = 1'b1;
      order_d     = iM0_ORDER;
      rw_d        = iM0_RW;
      addr_d      = iM0_ADDR;
      data_d      = iM0_DATA;
      pref_d      = 1'b1;
    end else if (gnt1_s) begin
      out_valid_d = 1'b1;
      order_d     = iM1_ORDER;
      rw_d        = iM1_RW;
      addr_d      = iM1_ADDR;
      data_d      = iM1_DATA;
      pref_d      = 1'b0;
    end else if (!iIO_BUSY) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (push_s) begin
      own_d[wr_ptr_q] = gnt1_s;
      wr_ptr_d        = wr_ptr_q + P_TAG_AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + P_TAG_AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (P_TAG_AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (P_TAG_AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    // Returns with nothing outstanding are dropped but flagged until reset.
    if (iIO_VALID && !fifo_ne_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      out_valid_q <= 1'b0;
      order_q     <= 2'b00;
      rw_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      data_q      <= 32'h0000_0000;
      pref_q      <= 1'b0;
      own_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      order_q     <= order_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pref_q      <= pref_d;
      own_q       <= own_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized scoreboard bench for io_bus_arbiter against a queue-based reference model.
module tb_io_bus_arbiter;
  localparam int DEPTH = 4;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        m0_req, m0_rw, m0_busy, m1_req, m1_rw, m1_busy;
  logic [1:0]  m0_order, m1_order;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
  logic        io_busy, io_valid;
  logic [31:0] io_data;
  logic        oM0_BUSY, oM1_BUSY, oM0_VALID, oM1_VALID;
  logic [31:0] oM0_DATA, oM1_DATA;
  logic        oIO_REQ, oIO_RW, oIO_BUSY, oERR_UNEXP;
  logic [1:0]  oIO_ORDER;
  logic [31:0] oIO_ADDR, oIO_DATA;

  io_bus_arbiter #(.P_TAG_DEPTH(DEPTH), .P_TAG_AW(2)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iM0_REQ(m0_req), .oM0_BUSY(oM0_BUSY), .iM0_ORDER(m0_order), .iM0_RW(m0_rw),
    .iM0_ADDR(m0_addr), .iM0_DATA(m0_data), .oM0_VALID(oM0_VALID), .iM0_BUSY(m0_busy),
    .oM0_DATA(oM0_DATA),
    .iM1_REQ(m1_req), .oM1_BUSY(oM1_BUSY), .iM1_ORDER(m1_order), .iM1_RW(m1_rw),
    .iM1_ADDR(m1_addr), .iM1_DATA(m1_data), .oM1_VALID(oM1_VALID), .iM1_BUSY(m1_busy),
    .oM1_DATA(oM1_DATA),
    .oIO_REQ(oIO_REQ), .iIO_BUSY(io_busy), .oIO_ORDER(oIO_ORDER), .oIO_RW(oIO_RW),
    .oIO_ADDR(oIO_ADDR), .oIO_DATA(oIO_DATA), .iIO_VALID(io_valid), .oIO_BUSY(oIO_BUSY),
    .iIO_DATA(io_data), .oERR_UNEXP(oERR_UNEXP)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct packed {logic [1:0] order; logic rw; logic [31:0] addr; logic [31:0] data;} io_t;
  typedef struct packed {logic master; logic [31:0] data;} ret_t;
  typedef struct packed {logic b0, b1, v0, v1, ioreq, iobusy, err;} chk_t;

  io_t  exp_io_q[$];
  ret_t exp_ret_q[$];
  chk_t chk_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [66:0] got, input logic [66:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: owner FIFO is a plain queue of master ids.
  int own_q[$];
  bit m_ov, m_pref, m_err;

  initial forever begin
    chk_t c;
    bit has, ibo, pop, room, cl, e0, e1;
    int head, win;
    @(posedge iCLOCK);
    #2;
    if (!inRESET) begin
      m_ov = 0; m_pref = 0; m_err = 0;
      own_q.delete(); exp_io_q.delete(); exp_ret_q.delete();
      chk_q.push_back('0);
    end else begin
      has  = own_q.size() > 0;
      head = has ? own_q[0] : 0;
      ibo  = has && ((head == 1) ? m1_busy : m0_busy);
      pop  = io_valid && has && !ibo;
      room = (own_q.size() < DEPTH) || pop;
      cl   = !m_ov || !io_busy;
      e0   = m0_req && cl && (!m0_rw || room);
      e1   = m1_req && cl && (!m1_rw || room);
      win  = -1;
      if (e0 && e1) win = m_pref ? 1 : 0;
      else if (e0) win = 0;
      else if (e1) win = 1;
      c.b0     = !cl || (m0_rw && !room) || (win == 1);
      c.b1     = !cl || (m1_rw && !room) || (win == 0);
      c.v0     = io_valid && has && head == 0;
      c.v1     = io_valid && has && head == 1;
      c.ioreq  = m_ov;
      c.iobusy = ibo;
      c.err    = m_err;
      chk_q.push_back(c);
      if (io_valid && !has) m_err = 1;
      if (pop) begin
        exp_ret_q.push_back({head[0], io_data});
        void'(own_q.pop_front());
      end
      if (win == 0) exp_io_q.push_back({m0_order, m0_rw, m0_addr, m0_data});
      if (win == 1) exp_io_q.push_back({m1_order, m1_rw, m1_addr, m1_data});
      if (win >= 0) begin
        if ((win == 0 && m0_rw) || (win == 1 && m1_rw)) own_q.push_back(win);
        m_pref = (win == 0);
        m_ov   = 1;
      end else if (!io_busy) begin
        m_ov = 0;
      end
    end
  end

  // Monitor: compares per-cycle outputs and every completed handshake.
  initial forever begin
    chk_t c;
    ret_t r;
    io_t  t;
    @(posedge iCLOCK);
    #3;
    if (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      check("m0_busy", 67'(oM0_BUSY), 67'(c.b0));
      check("m1_busy", 67'(oM1_BUSY), 67'(c.b1));
      check("m0_valid", 67'(oM0_VALID), 67'(c.v0));
      check("m1_valid", 67'(oM1_VALID), 67'(c.v1));
      check("io_req", 67'(oIO_REQ), 67'(c.ioreq));
      check("io_busy", 67'(oIO_BUSY), 67'(c.iobusy));
      check("err_unexp", 67'(oERR_UNEXP), 67'(c.err));
    end
    if (inRESET) begin
      if (oIO_REQ && !io_busy) begin
        if (exp_io_q.size() == 0) check("io_extra", 67'(1), 67'(0));
        else begin
          t = exp_io_q.pop_front();
          check("io_txn", {oIO_ORDER, oIO_RW, oIO_ADDR, oIO_DATA}, t);
        end
      end
      if ((oM0_VALID && !m0_busy) || (oM1_VALID && !m1_busy)) begin
        if (exp_ret_q.size() == 0) check("ret_extra", 67'(1), 67'(0));
        else begin
          r = exp_ret_q.pop_front();
          check("ret", 67'({oM1_VALID, oM1_VALID ? oM1_DATA : oM0_DATA}), 67'(r));
        end
      end
    end
  end

  function automatic bit rnd(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic idle();
    m0_req = 0; m0_rw = 0; m0_order = 2'd0; m0_addr = 32'd0; m0_data = 32'd0; m0_busy = 0;
    m1_req = 0; m1_rw = 0; m1_order = 2'd0; m1_addr = 32'd0; m1_data = 32'd0; m1_busy = 0;
    io_busy = 0; io_valid = 0; io_data = 32'd0;
  endtask

  task automatic do_reset();
    @(posedge iCLOCK); #1;
    idle();
    inRESET = 0;
    repeat (2) @(posedge iCLOCK);
    #1 inRESET = 1;
  endtask

  task automatic run(input int p_req, p_rd, p_iob, p_val, p_mb, ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge iCLOCK); #1;
      m0_req = rnd(p_req); m0_rw = rnd(p_rd); m0_order = 2'($urandom_range(3, 0));
      m0_addr = $urandom; m0_data = $urandom; m0_busy = rnd(p_mb);
      m1_req = rnd(p_req); m1_rw = rnd(p_rd); m1_order = 2'($urandom_range(3, 0));
      m1_addr = $urandom; m1_data = $urandom; m1_busy = rnd(p_mb);
      io_busy = rnd(p_iob); io_valid = rnd(p_val); io_data = $urandom;
    end
  endtask

  // Phase knobs: req%, read%, io_busy%, io_valid%, master_busy%, cycles
  int ph[6][6] = '{
    '{100,   0,  0,  0,  0,  40},
    '{ 80,  50, 60, 40, 30, 300},
    '{100, 100, 10,  5,  0, 200},
    '{ 70,  60, 30, 50, 40, 800},
    '{ 60, 100,  0, 90, 70, 300},
    '{  0,   0,  0, 50,  0,  20}
  };

  initial begin
    inRESET = 0;
    idle();
    for (int p = 0; p < 6; p++) begin
      do_reset();
      run(ph[p][0], ph[p][1], ph[p][2], ph[p][3], ph[p][4], ph[p][5]);
      run(0, 0, 0, 100, 0, 12);
      @(posedge iCLOCK); #4;
      check("io_drain", 67'(exp_io_q.size()), 67'(0));
      check("ret_drain", 67'(exp_ret_q.size()), 67'(0));
    end
    do_reset();
    repeat (2) @(posedge iCLOCK);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
